ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select/forwarding logic, directly upstream of the ALU/shifter.
- Captures decoded operands from ID each cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives alumux1_out/alumux2_out, which the shifter and ALU consume unchanged. Also flags load-use hazards back to the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.
- OP_W, 4, ALU operation code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_data  in  XLEN  register-file read port 1.
- id_rs2_data  in  XLEN  register-file read port 2.
- id_imm  in  XLEN  sign-extended immediate.
- id_pc  in  XLEN  instruction PC.
- id_rs1_addr  in  REG_AW  source register 1 index.
- id_rs2_addr  in  REG_AW  source register 2 index.
- id_rd_addr  in  REG_AW  destination register index.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_mux1_sel  in  2  operand-1 select: 0=rs1, 1=pc, 2=zero, 3=zero.
- id_mux2_sel  in  2  operand-2 select: 0=rs2, 1=imm, 2=const 4, 3=zero.
- id_aluop  in  OP_W  ALU/shift operation.
- stall  in  1  hold EX register contents.
- flush  in  1  insert bubble.
- mem_rd_addr  in  REG_AW  EX/MEM destination register.
- mem_rd_we  in  1  EX/MEM write enable.
- mem_fwd_data  in  XLEN  EX/MEM result.
- wb_rd_addr  in  REG_AW  MEM/WB destination register.
- wb_rd_we  in  1  MEM/WB write enable.
- wb_fwd_data  in  XLEN  MEM/WB result.
- ex_valid  out  1  EX holds a valid instruction.
- alumux1_out  out  XLEN  ALU/shifter operand 1.
- alumux2_out  out  XLEN  ALU/shifter operand 2.
- ex_aluop  out  OP_W  registered aluop.
- ex_rd_addr  out  REG_AW  registered rd.
- ex_rd_we  out  1  registered rd write enable, gated by ex_valid.
- ex_rs2_fwd  out  XLEN  forwarded rs2 value, used as store data.
- load_use_hazard  out  1  ID instruction depends on a load currently in EX.

Behaviour:
- Register update on rising edge, evaluated in this order:
  - rst: all stage registers clear to 0, so ex_valid=0, ex_rd_we=0, ex_aluop=0, ex_rd_addr=0. Registered data fields clear to 0, so alumux1_out and alumux2_out read 0 absent forwarding. rst overrides stall and flush.
  - flush: ex_valid, ex_rd_we and the registered is_load clear to 0; data fields are don't-care. flush overrides stall.
  - stall: all stage registers hold.
  - otherwise: capture every id_* field; ex_valid <= id_valid.
- Latency: one cycle from ID capture to EX outputs.
- Forwarding is combinational from registered state plus the mem_*/wb_* inputs, computed per source (rs1, rs2):
  - If mem_rd_we and mem_rd_addr == rs_addr and rs_addr != 0: use mem_fwd_data.
  - Else if wb_rd_we and wb_rd_addr == rs_addr and rs_addr != 0: use wb_fwd_data.
  - Else: use the registered read data.
  - EX/MEM has priority over MEM/WB when both match.
  - x0 is never forwarded.
- Operand muxes:
  - alumux1_out selects the forwarded rs1, pc, or 0 per the registered mux1_sel.
  - alumux2_out selects the forwarded rs2, imm, 32'd4, or 0 per mux2_sel.
  - Full XLEN bits are passed; the shifter uses the low 5 bits of alumux2_out.
- ex_rs2_fwd always carries the forwarded rs2, regardless of mux2_sel.
- load_use_hazard is combinational. It is 1 when all of the following hold:
  - ex_valid and registered is_load;
  - registered rd != 0;
  - id_valid;
  - rd equals id_rs1_addr or id_rs2_addr.
  - It is independent of stall and is not gated by flush.
- When ex_valid = 0: alumux outputs are don't-care, but ex_rd_we must be 0.

Optional Feature:
- FWD_EN:
  - Defined: forwarding as above.
  - Undefined: forwarding logic is omitted; operands always come from the registered read data, and the mem_*/wb_* inputs are unused. load_use_hazard remains; the hazard unit must then stall for all RAW hazards.

Decomposition:
- Shared package holds:
  - mux select encodings (MUX1_RS1/PC/ZERO, MUX2_RS2/IMM/FOUR/ZERO);
  - XLEN, REG_AW, OP_W;
  - aluop codes shared with the ALU/shifter.
- One sub-module, fwd_select: a single-operand forwarding comparator/mux, instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ex_rd_we=0, alumux1_out=0, alumux2_out=0.
- Basic capture: id_rs1_data=1, id_imm=8, mux1_sel=0, mux2_sel=1, no forwarding matches -> next cycle alumux1_out=1, alumux2_out=8, ex_valid=1.
- Forward priority: rs1_addr=5, mem_rd_addr=5 with mem_fwd_data=32'hFFFF0000, wb_rd_addr=5 with wb_fwd_data=32'hFFFFFFFE, both we=1 -> alumux1_out=32'hFFFF0000. Drop mem_rd_we -> alumux1_out=32'hFFFFFFFE.
- x0 guard: rs2_addr=0, mem_rd_addr=0, mem_rd_we=1, mem_fwd_data=7, id_rs2_data=0 -> alumux2_out=0.
- Stall/flush: stall=1 for 3 cycles while id_* change -> outputs unchanged. stall=1 with flush=1 -> ex_valid=0, ex_rd_we=0.
- Load-use: a load with rd=3 in EX and id_rs2_addr=3, id_valid=1 -> load_use_hazard=1. With rd=0 instead -> load_use_hazard=0.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared widths, operand-mux encodings and ALU op codes for the EX operand stage
package ex_operand_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 4;

    typedef enum logic [1:0] {
        MUX1_RS1      = 2'd0,
        MUX1_PC       = 2'd1,
        MUX1_ZERO     = 2'd2,
        MUX1_ZERO_ALT = 2'd3
    } mux1_sel_e;

    typedef enum logic [1:0] {
        MUX2_RS2  = 2'd0,
        MUX2_IMM  = 2'd1,
        MUX2_FOUR = 2'd2,
        MUX2_ZERO = 2'd3
    } mux2_sel_e;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } aluop_e;

endpackage

// File: rtl/ex_operand_stage_fwd_select.sv
// rtl/ex_operand_stage_fwd_select.sv - single-source forwarding comparator/mux, EX/MEM over MEM/WB, x0 never forwarded
module fwd_select
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN   = ex_operand_stage_pkg::XLEN,
    parameter int REG_AW = ex_operand_stage_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_we,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic [XLEN-1:0]   fwd_data
);

    logic rs_nonzero;
    assign rs_nonzero = (rs_addr != '0);

    always_comb begin
        fwd_data = rs_data;
        if (rs_nonzero && mem_rd_we && (mem_rd_addr == rs_addr)) begin
            fwd_data = mem_fwd_data;
        end else if (rs_nonzero && wb_rd_we && (wb_rd_addr == rs_addr)) begin
            fwd_data = wb_fwd_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand select; forwarding enabled by FWD_EN
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN   = ex_operand_stage_pkg::XLEN,
    parameter int REG_AW = ex_operand_stage_pkg::REG_AW,
    parameter int OP_W   = ex_operand_stage_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [1:0]        id_mux1_sel,
    input  logic [1:0]        id_mux2_sel,
    input  logic [OP_W-1:0]   id_aluop,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_we,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alumux1_out,
    output logic [XLEN-1:0]   alumux2_out,
    output logic [OP_W-1:0]   ex_aluop,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_rd_we,
    output logic [XLEN-1:0]   ex_rs2_fwd,
    output logic              load_use_hazard
);

    logic              valid_q;
    logic              rd_we_q;
    logic              is_load_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   pc_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [REG_AW-1:0] rd_addr_q;
    mux1_sel_e         mux1_sel_q;
    mux2_sel_e         mux2_sel_q;
    logic [OP_W-1:0]   aluop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rd_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            mux1_sel_q <= MUX1_RS1;
            mux2_sel_q <= MUX2_RS2;
            aluop_q    <= '0;
        end else if (flush) begin
            // Only the control bits matter for a bubble; data fields are left as-is.
            valid_q    <= 1'b0;
            rd_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
        end else if (!stall) begin
            valid_q    <= id_valid;
            rd_we_q    <= id_rd_we;
            is_load_q  <= id_is_load;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            pc_q       <= id_pc;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rd_addr_q  <= id_rd_addr;
            mux1_sel_q <= mux1_sel_e'(id_mux1_sel);
            mux2_sel_q <= mux2_sel_e'(id_mux2_sel);
            aluop_q    <= id_aluop;
        end
    end

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

`ifdef FWD_EN
    fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr      (rs1_addr_q),
        .rs_data      (rs1_data_q),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_we    (mem_rd_we),
        .mem_fwd_data (mem_fwd_data),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_we     (wb_rd_we),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs1_fwd)
    );

    fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr      (rs2_addr_q),
        .rs_data      (rs2_data_q),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_we    (mem_rd_we),
        .mem_fwd_data (mem_fwd_data),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_we     (wb_rd_we),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs2_fwd)
    );
`else
    // Without forwarding the hazard unit stalls every RAW hazard, so read data is always current.
    assign rs1_fwd = rs1_data_q;
    assign rs2_fwd = rs2_data_q;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_rd_addr, mem_rd_we, mem_fwd_data,
                                 wb_rd_addr, wb_rd_we, wb_fwd_data,
                                 rs1_addr_q, rs2_addr_q};
`endif

    always_comb begin
        alumux1_out = '0;
        case (mux1_sel_q)
            MUX1_RS1: alumux1_out = rs1_fwd;
            MUX1_PC:  alumux1_out = pc_q;
            default:  alumux1_out = '0;
        endcase
    end

    always_comb begin
        alumux2_out = '0;
        case (mux2_sel_q)
            MUX2_RS2:  alumux2_out = rs2_fwd;
            MUX2_IMM:  alumux2_out = imm_q;
            MUX2_FOUR: alumux2_out = XLEN'(4);
            default:   alumux2_out = '0;
        endcase
    end

    assign ex_valid   = valid_q;
    assign ex_aluop   = aluop_q;
    assign ex_rd_addr = rd_addr_q;
    assign ex_rd_we   = valid_q & rd_we_q;
    assign ex_rs2_fwd = rs2_fwd;

    assign load_use_hazard = valid_q && is_load_q && (rd_addr_q != '0) && id_valid &&
                             ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));

endmodule
